// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control FSM: fetch/decode/execute/memory/writeback sequencing
// with a bounded memory wait timeout. Define ILLEGAL_OPCODE_TRAP_EN to trap unlisted opcodes.
module multicycle_control_fsm #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                memReady,
  output logic                memRead,
  output logic                memWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                pcWrite,
  output logic                branch,
  output logic [2:0]          branchType,
  output logic [1:0]          pcSrc,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                ALUSrcAControl,
  output logic [1:0]          ALUSrcBControl,
  output logic                regDst,
  output logic                regWrite,
  output logic                memToReg,
  output logic                jmp,
  output logic                link,
  output logic                busError,
  output logic                illegalOp,
  output logic [3:0]          state
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_BGT  = OPCODE_W'(6'b001110);
  localparam logic [OPCODE_W-1:0] OP_BGE  = OPCODE_W'(6'b010001);
  localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(6'b010010);
  localparam logic [OPCODE_W-1:0] OP_BLE  = OPCODE_W'(6'b010011);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'b000011);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = '1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4, S_ALU_WB = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_READ = 4'd7,
    S_MEM_WB = 4'd8, S_MEM_WRITE = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , S_TRAP = 4'd12
`endif
  } state_t;

  state_t              st;
  logic [OPCODE_W-1:0] op_q;
  logic [CW-1:0]       wait_cnt;
  logic                mem_st, timeout, r_type;

  assign state   = st;
  assign r_type  = (op_q == OP_R);
  assign mem_st  = (st == S_FETCH) || (st == S_MEM_READ) || (st == S_MEM_WRITE);
  // memReady wins over the timeout when both land in the same cycle
  assign timeout = mem_st && !memReady && (wait_cnt == CW'(MEM_TIMEOUT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st       <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
    end else if (timeout) begin
      st       <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= (mem_st && !memReady) ? wait_cnt + CW'(1) : '0;
      case (st)
        S_IDLE:      st <= S_FETCH;
        S_FETCH:     if (memReady) st <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_R:                                     st <= S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI:                 st <= S_EXEC_I;
            OP_LW, OP_SW:                             st <= S_MEM_ADDR;
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: st <= S_BRANCH;
            OP_J, OP_JAL:                             st <= S_JUMP;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            default:                                  st <= S_TRAP;
`else
            default:                                  st <= S_FETCH;
`endif
          endcase
        end
        S_EXEC_R, S_EXEC_I: st <= S_ALU_WB;
        S_MEM_ADDR:  st <= (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (memReady) st <= S_MEM_WB;
        S_MEM_WRITE: if (memReady) st <= S_FETCH;
        default:     st <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    memRead = 1'b0; memWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b0; pcWrite = 1'b0;
    branch = 1'b0; branchType = 3'b000; pcSrc = 2'b00; ALUOp = ALU_ADD;
    ALUSrcAControl = 1'b0; ALUSrcBControl = 2'b00; regDst = 1'b0; regWrite = 1'b0;
    memToReg = 1'b0; jmp = 1'b0; link = 1'b0; illegalOp = 1'b0;
    busError = timeout;
    case (st)
      S_FETCH: begin
        memRead        = !timeout;
        ALUSrcBControl = 2'b01;
        IRWrite        = memReady;
        pcWrite        = memReady;
      end
      S_DECODE: ALUSrcBControl = 2'b11;
      // ALU controls stay up through writeback so ALU_WB reflects the op
      S_EXEC_R, S_EXEC_I, S_ALU_WB: begin
        ALUSrcAControl = 1'b1;
        if (r_type) begin
          ALUSrcBControl = 2'b00;
          ALUOp          = ALU_FUNCT;
        end else begin
          ALUSrcBControl = 2'b10;
          ALUOp = (op_q == OP_ANDI) ? ALU_AND : (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
        end
        if (st == S_ALU_WB) begin
          regWrite = 1'b1;
          regDst   = r_type;
        end
      end
      S_MEM_ADDR: begin
        ALUSrcAControl = 1'b1;
        ALUSrcBControl = 2'b10;
      end
      S_MEM_READ: begin
        memRead = !timeout;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEM_WRITE: begin
        memWrite = !timeout;
        IorD     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcAControl = 1'b1;
        ALUOp          = ALU_SUB;
        branch         = 1'b1;
        pcSrc          = 2'b01;
        case (op_q)
          OP_BNE:  branchType = 3'b001;
          OP_BGT:  branchType = 3'b010;
          OP_BGE:  branchType = 3'b011;
          OP_BLT:  branchType = 3'b100;
          OP_BLE:  branchType = 3'b101;
          default: branchType = 3'b000;
        endcase
      end
      S_JUMP: begin
        jmp      = 1'b1;
        pcWrite  = 1'b1;
        pcSrc    = 2'b10;
        link     = (op_q == OP_JAL);
        regWrite = (op_q == OP_JAL);
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_TRAP: begin
        illegalOp = 1'b1;
        pcWrite   = 1'b1;
        pcSrc     = 2'b11;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-scenario tasks with hand-computed expectations.
module tb_multicycle_control_fsm;
  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4, S_ALU_WB = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_READ = 4'd7, S_MEM_WB = 4'd8,
    S_MEM_WRITE = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11, S_TRAP = 4'd12;

  logic clock = 1'b0, reset = 1'b1, memReady = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic memRead, memWrite, IorD, IRWrite, pcWrite, branch, ALUSrcAControl;
  logic regDst, regWrite, memToReg, jmp, link, busError, illegalOp;
  logic [2:0] branchType;
  logic [1:0] pcSrc, ALUSrcBControl;
  logic [3:0] ALUOp, state;
  logic [31:0] got, exp;
  int n_cmp = 0, n_err = 0;

  multicycle_control_fsm #(.OPCODE_W(6), .ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .memReady(memReady),
    .memRead(memRead), .memWrite(memWrite), .IorD(IorD), .IRWrite(IRWrite),
    .pcWrite(pcWrite), .branch(branch), .branchType(branchType), .pcSrc(pcSrc),
    .ALUOp(ALUOp), .ALUSrcAControl(ALUSrcAControl), .ALUSrcBControl(ALUSrcBControl),
    .regDst(regDst), .regWrite(regWrite), .memToReg(memToReg), .jmp(jmp), .link(link),
    .busError(busError), .illegalOp(illegalOp), .state(state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT in IDLE with reset released; one step() later it is in FETCH.
  task automatic start();
    reset = 1'b1; memReady = 1'b1; opcode = 6'd0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; #2;
    got = {memRead, memWrite, IorD, IRWrite, pcWrite, branch, branchType, pcSrc, ALUOp,
           ALUSrcAControl, ALUSrcBControl, regDst, regWrite, memToReg, jmp, link,
           busError, illegalOp, state};
    exp = '0;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_outputs: got %h want %h", got, exp); end
    start(); step(); #1;
    got = {state, memRead, ALUSrcBControl}; exp = {S_FETCH, 1'b1, 2'b01};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_to_fetch: got %h want %h", got, exp); end
  endtask

  task automatic test_rtype();
    start(); step(); opcode = 6'b000000; #1;
    got = {state, memRead, IorD, IRWrite, pcWrite, pcSrc, ALUOp, ALUSrcAControl, ALUSrcBControl};
    exp = {S_FETCH, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'b0000, 1'b0, 2'b01};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rtype_fetch: got %h want %h", got, exp); end
    step(); #1;
    got = {state, ALUSrcAControl, ALUSrcBControl, ALUOp}; exp = {S_DECODE, 1'b0, 2'b11, 4'b0000};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rtype_decode: got %h want %h", got, exp); end
    step(); opcode = 6'b100011; #1;  // late opcode change must be ignored
    got = {state, ALUSrcAControl, ALUSrcBControl, ALUOp}; exp = {S_EXEC_R, 1'b1, 2'b00, 4'b1111};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rtype_exec: got %h want %h", got, exp); end
    step(); #1;
    got = {state, regWrite, regDst, ALUOp, memToReg}; exp = {S_ALU_WB, 1'b1, 1'b1, 4'b1111, 1'b0};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rtype_wb: got %h want %h", got, exp); end
    step(); #1;
    got = {28'd0, state}; exp = {28'd0, S_FETCH};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rtype_refetch: got %h want %h", got, exp); end
  endtask

  task automatic test_itype();
    logic [5:0] ops [3];
    logic [3:0] aop [3];
    ops = '{6'b001000, 6'b001100, 6'b001101};
    aop = '{4'b0000, 4'b0010, 4'b0011};
    start(); step();
    for (int i = 0; i < 3; i++) begin
      opcode = ops[i];
      step(); step(); #1;
      got = {state, ALUSrcAControl, ALUSrcBControl, ALUOp}; exp = {S_EXEC_I, 1'b1, 2'b10, aop[i]};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL itype_exec[%0d]: got %h want %h", i, got, exp); end
      step(); #1;
      got = {state, regWrite, regDst}; exp = {S_ALU_WB, 1'b1, 1'b0};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL itype_wb[%0d]: got %h want %h", i, got, exp); end
      step();
    end
  endtask

  task automatic test_lw_wait();
    start(); step(); opcode = 6'b100011;
    step(); step(); #1;
    got = {state, ALUSrcAControl, ALUSrcBControl, ALUOp}; exp = {S_MEM_ADDR, 1'b1, 2'b10, 4'b0000};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lw_addr: got %h want %h", got, exp); end
    memReady = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      got = {state, memRead, IorD, regWrite, busError}; exp = {S_MEM_READ, 1'b1, 1'b1, 1'b0, 1'b0};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lw_wait[%0d]: got %h want %h", i, got, exp); end
      step();
    end
    memReady = 1'b1; #1;
    got = {state, memRead, IorD}; exp = {S_MEM_READ, 1'b1, 1'b1};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lw_ready: got %h want %h", got, exp); end
    step(); #1;
    got = {state, regWrite, memToReg, regDst, memRead}; exp = {S_MEM_WB, 1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lw_wb: got %h want %h", got, exp); end
    step(); #1;
    got = {28'd0, state}; exp = {28'd0, S_FETCH};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lw_cycle9_fetch: got %h want %h", got, exp); end
  endtask

  task automatic test_sw();
    start(); step(); opcode = 6'b101011;
    step(); step(); step(); #1;
    got = {state, memWrite, IorD, memRead, regWrite}; exp = {S_MEM_WRITE, 1'b1, 1'b1, 1'b0, 1'b0};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL sw_write: got %h want %h", got, exp); end
    step(); #1;
    got = {28'd0, state}; exp = {28'd0, S_FETCH};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL sw_refetch: got %h want %h", got, exp); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [6];
    logic [2:0] typ [6];
    ops = '{6'b000100, 6'b000101, 6'b001110, 6'b010001, 6'b010010, 6'b010011};
    typ = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    start(); step();
    for (int i = 0; i < 6; i++) begin
      opcode = ops[i];
      step(); step(); #1;
      got = {state, branch, branchType, pcSrc, ALUOp, ALUSrcAControl, ALUSrcBControl};
      exp = {S_BRANCH, 1'b1, typ[i], 2'b01, 4'b0001, 1'b1, 2'b00};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL branch[%0d]: got %h want %h", i, got, exp); end
      step(); #1;
      got = {28'd0, state}; exp = {28'd0, S_FETCH};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL branch_refetch[%0d]: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_jump();
    start(); step();
    for (int i = 0; i < 2; i++) begin
      opcode = (i == 0) ? 6'b000010 : 6'b000011;
      step(); step(); #1;
      got = {state, jmp, pcWrite, pcSrc, link, regWrite};
      exp = {S_JUMP, 1'b1, 1'b1, 2'b10, (i == 1), (i == 1)};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL jump[%0d]: got %h want %h", i, got, exp); end
      step();
    end
  endtask

  task automatic test_fetch_timeout();
    start(); step(); memReady = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 15; i++) begin
        #1;
        got = {state, busError, IRWrite, pcWrite}; exp = {S_FETCH, 1'b0, 1'b0, 1'b0};
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL fetch_wait[%0d][%0d]: got %h want %h", r, i, got, exp); end
        step();
      end
      #1;
      got = {state, busError, IRWrite, pcWrite}; exp = {S_FETCH, 1'b1, 1'b0, 1'b0};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL fetch_timeout[%0d]: got %h want %h", r, got, exp); end
      step();
    end
    memReady = 1'b1;
  endtask

  task automatic test_timeout_priority();
    start(); step(); opcode = 6'b100011;
    step(); step(); memReady = 1'b0; step();
    for (int i = 0; i < 15; i++) begin
      #1;
      got = {state, busError, memRead}; exp = {S_MEM_READ, 1'b0, 1'b1};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL prio_wait[%0d]: got %h want %h", i, got, exp); end
      step();
    end
    memReady = 1'b1; #1;
    got = {state, busError, memRead}; exp = {S_MEM_READ, 1'b0, 1'b1};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL prio_ready: got %h want %h", got, exp); end
    step(); #1;
    got = {state, regWrite, memToReg}; exp = {S_MEM_WB, 1'b1, 1'b1};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL prio_wb: got %h want %h", got, exp); end
    step();
  endtask

  task automatic test_illegal();
    start(); step(); opcode = 6'b111111;
    step(); step(); #1;
`ifdef ILLEGAL_OPCODE_TRAP_EN
    got = {state, illegalOp, pcSrc, pcWrite}; exp = {S_TRAP, 1'b1, 2'b11, 1'b1};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL illegal_trap: got %h want %h", got, exp); end
    step(); #1;
`endif
    got = {state, illegalOp}; exp = {S_FETCH, 1'b0};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL illegal_refetch: got %h want %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    start(); step(); opcode = 6'b100011;
    step(); step(); memReady = 1'b0; step(); #1;
    got = {state, memRead}; exp = {S_MEM_READ, 1'b1};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL mid_inflight: got %h want %h", got, exp); end
    reset = 1'b1; #1;
    got = {memRead, memWrite, IorD, IRWrite, pcWrite, branch, branchType, pcSrc, ALUOp,
           ALUSrcAControl, ALUSrcBControl, regDst, regWrite, memToReg, jmp, link,
           busError, illegalOp, state};
    exp = '0;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL mid_reset_outputs: got %h want %h", got, exp); end
    memReady = 1'b1;
    step(); reset = 1'b0; #1;
    got = {28'd0, state}; exp = {28'd0, S_IDLE};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL mid_idle: got %h want %h", got, exp); end
    step(); #1;
    got = {state, memRead}; exp = {S_FETCH, 1'b1};
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL mid_fetch: got %h want %h", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jump();
    test_fetch_timeout();
    test_timeout_priority();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
